// File: rtl/ct_f_sram_pkg.sv
// Shared SRAM-side definitions for the single-port SRAM BIST.
// FSM state encoding and active-low control levels.
package ct_f_sram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_CHK0,
    S_WR1,
    S_RD1,
    S_CHK1,
    S_DONE
  } bist_state_e;

  localparam logic SRAM_CEN_ON  = 1'b0;
  localparam logic SRAM_CEN_OFF = 1'b1;
  localparam logic SRAM_GWEN_WR = 1'b0;
  localparam logic SRAM_GWEN_RD = 1'b1;

endpackage

// File: rtl/ct_f_spsram_bist_ctrl.sv
// March-style fill/readback BIST for a single-port SRAM macro.
// Two passes (true, inverted pattern); first miscompare is captured.
module ct_f_spsram_bist_ctrl
  import ct_f_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'hA5C3_5A3C
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);

  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  inv
  );
    logic [DATA_WIDTH-1:0] p;
    p = SEED_W ^ DATA_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic                  cen_q, cen_d;
  logic                  gwen_q, gwen_d;
  logic [DATA_WIDTH-1:0] wen_q, wen_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  cvld_q, cvld_d;
  logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
  logic [DATA_WIDTH-1:0] cexp_q, cexp_d;

  logic [ADDR_WIDTH-1:0] a_nxt;
  logic                  a_last;
  logic                  is_rd;

  assign a_nxt  = a_q + 1'b1;
  assign a_last = &a_q;
  assign is_rd  = (state_q == S_RD0) || (state_q == S_RD1);

  // Next-state, SRAM command, compare pipe and capture logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cen_d   = SRAM_CEN_OFF;
    gwen_d  = SRAM_GWEN_RD;
    wen_d   = '1;
    d_d     = d_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    // A read visible this cycle returns Q next cycle.
    cvld_d  = is_rd;
    caddr_d = a_q;
    cexp_d  = pat(a_q, state_q == S_RD1);

    if (cvld_q && (Q != cexp_q) && !fail_q) begin
      fail_d  = 1'b1;
      faddr_d = caddr_q;
      fdata_d = Q;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WR0;
          a_d     = '0;
          cen_d   = SRAM_CEN_ON;
          gwen_d  = SRAM_GWEN_WR;
          wen_d   = '0;
          d_d     = pat('0, 1'b0);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
        end
      end
      S_WR0, S_WR1: begin
        cen_d = SRAM_CEN_ON;
        if (a_last) begin
          state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
          a_d     = '0;
        end else begin
          a_d    = a_nxt;
          gwen_d = SRAM_GWEN_WR;
          wen_d  = '0;
          d_d    = pat(a_nxt, state_q == S_WR1);
        end
      end
      S_RD0, S_RD1: begin
        if (a_last) begin
          state_d = (state_q == S_RD0) ? S_CHK0 : S_CHK1;
        end else begin
          a_d   = a_nxt;
          cen_d = SRAM_CEN_ON;
        end
      end
      S_CHK0: begin
        state_d = S_WR1;
        a_d     = '0;
        cen_d   = SRAM_CEN_ON;
        gwen_d  = SRAM_GWEN_WR;
        wen_d   = '0;
        d_d     = pat('0, 1'b1);
      end
      S_CHK1: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state: FSM, address counter, SRAM outputs, compare pipe, capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      cen_q   <= SRAM_CEN_OFF;
      gwen_q  <= SRAM_GWEN_RD;
      wen_q   <= '1;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      cvld_q  <= 1'b0;
      caddr_q <= '0;
      cexp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cen_q   <= cen_d;
      gwen_q  <= gwen_d;
      wen_q   <= wen_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      cexp_q  <= cexp_d;
    end
  end

  assign A         = a_q;
  assign CEN       = cen_q;
  assign GWEN      = gwen_q;
  assign WEN       = wen_q;
  assign D         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_ct_f_spsram_bist_ctrl.sv
// Directed bench for the SRAM BIST with a 16x32 behavioural SRAM.
// Faults: bit0 inversion at one address, bit0 stuck-at-1 at another.
module tb_ct_f_spsram_bist_ctrl;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [3:0]  A;
  logic        CEN;
  logic        GWEN;
  logic [31:0] WEN;
  logic [31:0] D;
  logic [31:0] Q;
  logic        busy;
  logic        done;
  logic        fail;
  logic [3:0]  fail_addr;
  logic [31:0] fail_data;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem [16];
  logic [31:0] q_raw;
  logic [3:0]  rd_a;
  logic        flip_en;
  logic [3:0]  flip_a;
  logic        sa1_en;
  logic [3:0]  sa1_a;

  ct_f_spsram_bist_ctrl #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(32),
    .SEED(32'hA5C3_5A3C)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .A(A),
    .CEN(CEN),
    .GWEN(GWEN),
    .WEN(WEN),
    .D(D),
    .Q(Q),
    .busy(busy),
    .done(done),
    .fail(fail),
    .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (D & ~WEN) | (mem[A] & WEN);
      end else begin
        q_raw <= mem[A];
        rd_a  <= A;
      end
    end
  end

  assign Q = (q_raw ^ ((flip_en && rd_a == flip_a) ? 32'h1 : 32'h0))
           | ((sa1_en && rd_a == sa1_a) ? 32'h1 : 32'h0);

  function automatic logic [31:0] pat(input int a, input bit inv);
    logic [31:0] p;
    p = 32'hA5C3_5A3C ^ 32'(a);
    return inv ? ~p : p;
  endfunction

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full run from a start pulse; pulse_k injects a start mid-run.
  task automatic run(
    input int          pulse_k,
    input logic        exp_fail,
    input logic [3:0]  exp_addr,
    input logic [31:0] exp_data
  );
    int nwr;
    int nrd;
    int a;
    nwr = 0;
    nrd = 0;
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk("start_clr", {busy, done, fail, fail_addr, fail_data},
        {1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
    for (int k = 0; k <= 66; k++) begin
      if (!CEN && !GWEN) nwr++;
      if (!CEN && GWEN) nrd++;
      if (k < 16 || (k >= 33 && k <= 48)) begin
        a = (k < 16) ? k : k - 33;
        chk("wr_proto", {CEN, GWEN, WEN, A, D},
            {1'b0, 1'b0, 32'h0, 4'(a), pat(a, k >= 33)});
      end
      if (k == 65) begin
        chk("pre_done", {busy, done}, {1'b1, 1'b0});
      end
      if (k == 66) begin
        chk("done_lvl", {busy, done, CEN}, {1'b0, 1'b1, 1'b1});
        chk("fail_cap", {fail, fail_addr, fail_data},
            {exp_fail, exp_addr, exp_data});
        chk("acc_cnt", {32'(nwr), 32'(nrd)}, {32'd32, 32'd32});
      end
      start = (k == pulse_k);
      if (k < 66) begin
        @(posedge CLK);
        #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    RST     = 1'b1;
    start   = 1'b0;
    flip_en = 1'b0;
    flip_a  = 4'h0;
    sa1_en  = 1'b0;
    sa1_a   = 4'h0;
    q_raw   = 32'h0;
    rd_a    = 4'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_sram", {CEN, GWEN, WEN, A, D},
        {1'b1, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0});
    chk("rst_stat", {busy, done, fail, fail_addr, fail_data},
        {1'b0, 1'b0, 1'b0, 4'h0, 32'h0});

    // start together with RST is ignored
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk("rst_win", {busy, CEN}, {1'b0, 1'b1});
    @(negedge CLK);
    RST = 1'b0;

    // clean run
    run(-1, 1'b0, 4'h0, 32'h0);

    // inverted bit0 at addr 5: RD0 miscompare, RD1 must not overwrite
    flip_en = 1'b1;
    flip_a  = 4'd5;
    run(-1, 1'b1, 4'd5, 32'hA5C3_5A38);

    // restart from DONE; stuck-at-1 bit0 at 5 only hits RD1 (~P(5))
    flip_en = 1'b0;
    sa1_en  = 1'b1;
    sa1_a   = 4'd5;
    run(-1, 1'b1, 4'd5, 32'h5A3C_A5C7);

    // addr 3 fails in RD0, addr 9 in RD1: first one kept
    flip_en = 1'b1;
    flip_a  = 4'd3;
    sa1_a   = 4'd9;
    run(-1, 1'b1, 4'd3, 32'hA5C3_5A3E);
    flip_en = 1'b0;
    sa1_en  = 1'b0;

    // reset mid-RD0
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("mid_rd0", {busy, CEN, GWEN}, {1'b1, 1'b0, 1'b1});
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst", {CEN, busy, done, fail, A, D},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst", {CEN, busy}, {1'b1, 1'b0});

    // clean run with a start pulse during WR1 (ignored)
    run(40, 1'b0, 4'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
